spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Converts one decoded UART command frame (opcode, address, 16-bit data) into a 4-byte SPI transaction.
//  Drives the byte-level handshake of SPI_Master_With_Single_CS under a single chip-select window.
//  Returns read data and a completion or error status toward the UART response path.
//  Sits between the command-frame FSM (cmd/address/dataMsb/dataLsb registers) and the SPI master.
// PARAMETERS
//  MAX_BYTES_PER_CS  4     must match the SPI master; the sequencer always issues exactly 4 bytes
//  TIMEOUT_CYCLES    4096  clk cycles allowed per byte before the transaction is aborted
//  CNT_W             $clog2(MAX_BYTES_PER_CS+1)  width of spi_tx_count
// PORTS
//  clk            in   1      clock
//  reset          in   1      reset, asynchronous, active-high
//  cmd_valid      in   1      1-cycle pulse: frame fields valid
//  cmd_op         in   8      opcode: OP_WR=8'h01, OP_RD=8'h02
//  cmd_addr       in   8      target register address
//  cmd_wdata      in   16     write data {msb,lsb}
//  cmd_ready      out  1      high in IDLE only
//  cmd_dropped    out  1      1-cycle pulse: cmd_valid seen while not ready
//  spi_tx_count   out  CNT_W  bytes per CS; constant 4
//  spi_tx_byte    out  8      byte to the master
//  spi_tx_dv      out  1      1-cycle byte strobe
//  spi_tx_ready   in   1      master ready for the next byte
//  spi_rx_dv      in   1      1-cycle pulse: MISO byte complete
//  spi_rx_byte    in   8      MISO byte
//  rsp_valid      out  1      1-cycle pulse: transaction finished
//  rsp_code       out  2      00 OK, 01 BAD_OP, 10 TIMEOUT
//  rsp_rdata      out  16     read data {byte2,byte3}; 16'h0 for writes and errors
//  busy           out  1      high whenever the state is not IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, every output 0 except cmd_ready=1, spi_tx_count=4; all internal registers 0.
//  IDLE: when cmd_valid, latch op/addr/wdata, clear idx, and go to CHECK.
//  CHECK: if op is OP_WR or OP_RD, go to SEND.
//   Otherwise set rsp_code=BAD_OP and go to RESP; no SPI activity occurs.
//  Byte map, idx 0..3:
//   - WR: op, addr, wdata[15:8], wdata[7:0].
//   - RD: op, addr, 8'h00, 8'h00.
//  SEND: wait for spi_tx_ready=1, then assert spi_tx_dv for exactly 1 cycle with spi_tx_byte=map[idx].
//   Go to WAIT_RX and clear the timer.
//  WAIT_RX: on spi_rx_dv, if op is RD and idx is 2 or 3, store spi_rx_byte into rdata[15:8] or rdata[7:0].
//   Then, if idx==3, go to RESP with rsp_code=OK; else increment idx and go to SEND.
//  Never issue spi_tx_dv while in WAIT_RX, even if spi_tx_ready is high.
//  Timer: runs in SEND and WAIT_RX and clears on each byte strobe and on each spi_rx_dv.
//   When it reaches TIMEOUT_CYCLES-1, go to RESP with rsp_code=TIMEOUT and rdata=0.
//   The master is not reset; the spi_rx_dv that completes the aborted byte arrives later and is ignored in IDLE.
//  RESP: drive rsp_valid=1 for one cycle together with rsp_code and rsp_rdata, then go to IDLE.
//   rsp_code and rsp_rdata hold their values until the next RESP.
//  Latency, WR or RD with no stalls: cmd_valid -> first spi_tx_dv takes 2 cycles;
//   final spi_rx_dv -> rsp_valid takes 1 cycle.
//  cmd_valid when not in IDLE, including the same cycle as rsp_valid: the frame is discarded and cmd_dropped pulses.
//  spi_rx_dv in IDLE, CHECK, SEND or RESP is ignored.
//  Reset mid-transaction: immediate return to IDLE and the reset values; no rsp_valid is generated.
// STRUCTURE
//  Package spi_seq_pkg:
//   - OP_WR and OP_RD localparams.
//   - typedef enum state_t {IDLE, CHECK, SEND, WAIT_RX, RESP}.
//   - typedef enum logic[1:0] rsp_code_t {OK, BAD_OP, TIMEOUT}.
//  Sub-module spi_seq_timeout: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.
//  FSM: one always_ff block for the state register plus one always_comb block for next-state logic and strobes.
// TESTING
//  1. WR op=01, addr=0x12, wdata=0xBEEF, master model responds in 20 cycles/byte
//     -> tx bytes 01,12,BE,EF; 4 spi_tx_dv; rsp_code=00, rdata=0x0000.
//  2. RD op=02, addr=0x34, model returns MISO 00,00,CA,FE
//     -> tx bytes 02,34,00,00; rsp_rdata=0xCAFE, rsp_code=00.
//  3. op=0x7F -> rsp_valid 2 cycles after cmd_valid with rsp_code=01; no spi_tx_dv.
//  4. Model withholds spi_rx_dv after byte 1, TIMEOUT_CYCLES=16
//     -> rsp_code=10 exactly 16 cycles after the last activity; a late spi_rx_dv is ignored.
//  5. Second cmd_valid during a WR -> cmd_dropped pulses once; the first transaction completes unchanged.
//  6. Reset asserted after byte 2 -> busy=0 and cmd_ready=1 immediately; no rsp_valid; the next WR completes normally.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared opcodes, FSM state and response-code types for the SPI command sequencer.
package spi_seq_pkg;

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEND,
    WAIT_RX,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    BAD_OP  = 2'b01,
    TIMEOUT = 2'b10
  } rsp_code_t;

  // Byte issued at position idx of the 4-byte frame; reads shift out two dummy bytes.
  function automatic logic [7:0] tx_byte_map(input logic [7:0]  op,
                                             input logic [7:0]  addr,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = op;
      2'd1:    b = addr;
      2'd2:    b = (op == OP_WR) ? wdata[15:8] : 8'h00;
      default: b = (op == OP_WR) ? wdata[7:0]  : 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_seq_timeout.sv
// Per-byte watchdog: counts cycles of SPI inactivity and flags the abort point.
module spi_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The count would reach TIMEOUT_CYCLES-1 on the edge that ends this cycle; the FSM
  // leaves on that same edge, so the response lands TIMEOUT_CYCLES cycles after the
  // last byte strobe or received byte.
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 2);

  logic [W-1:0] r_cnt;

  // Inactivity counter: cleared on activity or outside the byte phases, else counts up.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Turns one decoded UART command frame into a 4-byte SPI transaction under one CS
// window and reports read data plus OK/BAD_OP/TIMEOUT status to the response path.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_op,
  input  logic [7:0]       cmd_addr,
  input  logic [15:0]      cmd_wdata,
  output logic             cmd_ready,
  output logic             cmd_dropped,
  output logic [CNT_W-1:0] spi_tx_count,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_dv,
  input  logic [7:0]       spi_rx_byte,
  output logic             rsp_valid,
  output logic [1:0]       rsp_code,
  output logic [15:0]      rsp_rdata,
  output logic             busy
);

  state_t      r_state, w_next_state;
  logic [7:0]  r_op, r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_idx;
  logic [15:0] r_rdata;
  rsp_code_t   r_rsp_code;
  logic [15:0] r_rsp_rdata;

  logic w_accept, w_bad_op, w_tx_fire, w_rx_take, w_done, w_timeout;
  logic w_tmr_en, w_tmr_clear, w_expired;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic plus the single-cycle event strobes that steer the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_bad_op     = 1'b0;
    w_tx_fire    = 1'b0;
    w_rx_take    = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: if (cmd_valid) begin
        w_accept     = 1'b1;
        w_next_state = CHECK;
      end
      CHECK: if (r_op == OP_WR || r_op == OP_RD) begin
        w_next_state = SEND;
      end else begin
        w_bad_op     = 1'b1;
        w_next_state = RESP;
      end
      SEND: if (spi_tx_ready) begin
        w_tx_fire    = 1'b1;
        w_next_state = WAIT_RX;
      end else if (w_expired) begin
        w_timeout    = 1'b1;
        w_next_state = RESP;
      end
      // A received byte beats a simultaneous expiry: the byte did arrive in time.
      WAIT_RX: if (spi_rx_dv) begin
        w_rx_take = 1'b1;
        if (r_idx == 2'd3) begin
          w_done       = 1'b1;
          w_next_state = RESP;
        end else begin
          w_next_state = SEND;
        end
      end else if (w_expired) begin
        w_timeout    = 1'b1;
        w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Port-level outputs decoded from state and strobes.
  always_comb begin
    cmd_ready   = (r_state == IDLE);
    busy        = (r_state != IDLE);
    cmd_dropped = cmd_valid && (r_state != IDLE);
    spi_tx_dv   = w_tx_fire;
    spi_tx_byte = w_tx_fire ? tx_byte_map(r_op, r_addr, r_wdata, r_idx) : 8'h00;
    rsp_valid   = (r_state == RESP);
    rsp_code    = r_rsp_code;
    rsp_rdata   = r_rsp_rdata;
  end

  assign spi_tx_count = CNT_W'(MAX_BYTES_PER_CS);

  // Frame capture, byte index, read-data assembly and the held response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_rsp_code  <= OK;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= cmd_op;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_idx   <= '0;
        r_rdata <= '0;
      end
      if (w_rx_take) begin
        if (r_op == OP_RD && r_idx == 2'd2) r_rdata[15:8] <= spi_rx_byte;
        if (r_op == OP_RD && r_idx == 2'd3) r_rdata[7:0]  <= spi_rx_byte;
        if (!w_done) r_idx <= r_idx + 2'd1;
      end
      if (w_bad_op || w_timeout) begin
        r_rsp_code  <= w_bad_op ? BAD_OP : TIMEOUT;
        r_rsp_rdata <= '0;
      end
      if (w_done) begin
        r_rsp_code  <= OK;
        r_rsp_rdata <= (r_op == OP_RD) ? {r_rdata[15:8], spi_rx_byte} : 16'h0000;
      end
    end
  end

  assign w_tmr_en    = (r_state == SEND) || (r_state == WAIT_RX);
  assign w_tmr_clear = !w_tmr_en || w_tx_fire || w_rx_take;

  spi_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_expired(w_expired)
  );

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench: a behavioural SPI master answers each byte after a programmable
// delay; a transaction-level model predicts the bytes, status, read data and timing.
module tb_spi_cmd_sequencer;
  import spi_seq_pkg::*;

  localparam int T_MAIN  = 4096;
  localparam int T_SHORT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, spi_tx_ready, spi_rx_dv;
  logic [7:0]  cmd_op, cmd_addr, spi_rx_byte;
  logic [15:0] cmd_wdata;

  // Two instances share all inputs; sel picks whose outputs the master and monitor follow.
  logic        a_ready, a_drop, a_tx_dv, a_rsp_valid, a_busy;
  logic [2:0]  a_count;
  logic [7:0]  a_tx_byte;
  logic [1:0]  a_code;
  logic [15:0] a_rdata;
  logic        t_ready, t_drop, t_tx_dv, t_rsp_valid, t_busy;
  logic [2:0]  t_count;
  logic [7:0]  t_tx_byte;
  logic [1:0]  t_code;
  logic [15:0] t_rdata;
  bit          sel;

  logic        o_ready, o_drop, o_tx_dv, o_rsp_valid, o_busy;
  logic [2:0]  o_count;
  logic [7:0]  o_tx_byte;
  logic [1:0]  o_code;
  logic [15:0] o_rdata;
  assign o_ready     = sel ? t_ready     : a_ready;
  assign o_drop      = sel ? t_drop      : a_drop;
  assign o_tx_dv     = sel ? t_tx_dv     : a_tx_dv;
  assign o_rsp_valid = sel ? t_rsp_valid : a_rsp_valid;
  assign o_busy      = sel ? t_busy      : a_busy;
  assign o_count     = sel ? t_count     : a_count;
  assign o_tx_byte   = sel ? t_tx_byte   : a_tx_byte;
  assign o_code      = sel ? t_code      : a_code;
  assign o_rdata     = sel ? t_rdata     : a_rdata;

  spi_cmd_sequencer #(.TIMEOUT_CYCLES(T_MAIN)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ready(a_ready), .cmd_dropped(a_drop), .spi_tx_count(a_count),
    .spi_tx_byte(a_tx_byte), .spi_tx_dv(a_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte), .rsp_valid(a_rsp_valid),
    .rsp_code(a_code), .rsp_rdata(a_rdata), .busy(a_busy));

  spi_cmd_sequencer #(.TIMEOUT_CYCLES(T_SHORT)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ready(t_ready), .cmd_dropped(t_drop), .spi_tx_count(t_count),
    .spi_tx_byte(t_tx_byte), .spi_tx_dv(t_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte), .rsp_valid(t_rsp_valid),
    .rsp_code(t_code), .rsp_rdata(t_rdata), .busy(t_busy));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus queued for the next cycle.
  bit          q_reset, q_valid;
  logic [7:0]  q_op, q_addr;
  logic [15:0] q_wdata;

  // Master model state and per-byte response delays.
  bit         m_pending;
  int         m_cnt, m_idx;
  int         m_dly[4];
  logic [7:0] m_miso[4];

  // Monitor records.
  int          cyc, cmd_cyc, first_tx, last_tx, last_rx, rsp_cyc, rsp_m_rx, rsp_m_tx;
  int          rsp_cnt, drop_cnt, viol;
  logic [1:0]  rsp_code_seen;
  logic [15:0] rsp_rdata_seen;
  logic [7:0]  tx_q[$];
  int          inj_q[$];

  // One clock cycle: drive inputs at the falling edge, then observe the settled outputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    reset     = q_reset;
    cmd_valid = q_valid;
    cmd_op    = q_op;
    cmd_addr  = q_addr;
    cmd_wdata = q_wdata;
    q_valid   = 1'b0;
    spi_rx_dv = 1'b0;
    if (m_pending) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        spi_rx_dv   = 1'b1;
        spi_rx_byte = m_miso[m_idx];
        m_pending   = 1'b0;
        last_rx     = cyc;
      end
    end
    spi_tx_ready = !m_pending;
    #1;
    if (o_tx_dv) begin
      if (!spi_tx_ready) viol++;
      if (tx_q.size() == 0) first_tx = cyc;
      tx_q.push_back(o_tx_byte);
      last_tx   = cyc;
      m_idx     = (tx_q.size() > 4) ? 3 : tx_q.size() - 1;
      m_pending = 1'b1;
      m_cnt     = m_dly[m_idx];
    end
    if (o_rsp_valid) begin
      rsp_cnt++;
      rsp_cyc        = cyc;
      rsp_code_seen  = o_code;
      rsp_rdata_seen = o_rdata;
      rsp_m_rx       = cyc - last_rx;
      rsp_m_tx       = cyc - last_tx;
    end
    if (o_drop) drop_cnt++;
  endtask

  task automatic apply_inj();
    if (inj_q.size() > 0 && (cyc + 1 - cmd_cyc) == inj_q[0]) begin
      void'(inj_q.pop_front());
      q_valid = 1'b1;
      q_op    = OP_WR;
      q_addr  = 8'hEE;
      q_wdata = 16'hDEAD;
    end
  endtask

  task automatic do_reset();
    q_reset = 1'b1;
    step();
    step();
    q_reset   = 1'b0;
    m_pending = 1'b0;
    step();
  endtask

  function automatic logic [7:0] ref_byte(input logic [7:0] op, input logic [7:0] addr,
                                          input logic [15:0] wd, input int k);
    logic [7:0] b[4];
    b[0] = op;
    b[1] = addr;
    b[2] = (op == OP_WR) ? wd[15:8] : 8'h00;
    b[3] = (op == OP_WR) ? wd[7:0]  : 8'h00;
    return b[k];
  endfunction

  // One complete frame, compared against the transaction-level expectation.
  task automatic run_txn(input string tag, input logic [7:0] op, input logic [7:0] addr,
                         input logic [15:0] wd, input int t_cur);
    bit          good;
    int          n_exp, n_inj;
    logic [1:0]  exp_code;
    logic [15:0] exp_rdata;
    good      = (op == OP_WR) || (op == OP_RD);
    exp_code  = OK;
    exp_rdata = 16'h0000;
    n_exp     = 0;
    if (!good) begin
      exp_code = BAD_OP;
    end else begin
      // A byte whose answer takes t_cur cycles or more aborts the frame after that byte.
      n_exp = 4;
      for (int k = 0; k < 4; k++)
        if (n_exp == 4 && exp_code == OK && m_dly[k] >= t_cur) begin
          n_exp    = k + 1;
          exp_code = TIMEOUT;
        end
      if (exp_code == OK && op == OP_RD) exp_rdata = {m_miso[2], m_miso[3]};
    end
    n_inj = inj_q.size();
    tx_q.delete();
    rsp_cnt = 0; drop_cnt = 0; viol = 0;
    first_tx = -1; last_tx = -1; last_rx = -1; rsp_cyc = -1;
    q_valid = 1'b1; q_op = op; q_addr = addr; q_wdata = wd;
    step();
    cmd_cyc = cyc;
    for (int i = 0; i < 3000 && rsp_cnt == 0; i++) begin apply_inj(); step(); end
    for (int i = 0; i < 300 && (m_pending || i < 4); i++) begin apply_inj(); step(); end
    inj_q.delete();
    check({tag, ".rsp_count"}, rsp_cnt, 1);
    check({tag, ".code"}, rsp_code_seen, exp_code);
    check({tag, ".rdata"}, rsp_rdata_seen, exp_rdata);
    check({tag, ".n_tx"}, tx_q.size(), n_exp);
    for (int k = 0; k < n_exp; k++)
      check({tag, $sformatf(".byte%0d", k)}, (k < tx_q.size()) ? 32'(tx_q[k]) : 32'hFFFF_FFFF,
            ref_byte(op, addr, wd, k));
    if (good) check({tag, ".cmd_to_tx"}, first_tx - cmd_cyc, 2);
    if (exp_code == OK)      check({tag, ".rx_to_rsp"}, rsp_m_rx, 1);
    if (exp_code == TIMEOUT) check({tag, ".tx_to_timeout"}, rsp_m_tx, t_cur);
    if (exp_code == BAD_OP)  check({tag, ".cmd_to_rsp"}, rsp_cyc - cmd_cyc, 2);
    check({tag, ".tx_while_busy"}, viol, 0);
    check({tag, ".dropped"}, drop_cnt, n_inj);
    check({tag, ".idle_after"}, {o_busy, o_ready}, 2'b01);
    check({tag, ".code_held"}, o_code, exp_code);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r_op_sel;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    spi_tx_ready = 1'b1; spi_rx_dv = 1'b0; spi_rx_byte = '0;
    sel = 1'b0; q_reset = 1'b1; q_valid = 1'b0; q_op = '0; q_addr = '0; q_wdata = '0;
    m_pending = 1'b0; m_cnt = 0; m_idx = 0; cyc = 0; cmd_cyc = 0;
    m_dly  = '{20, 20, 20, 20};
    m_miso = '{8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state.
    step(); step();
    q_reset = 1'b0;
    step();
    check("reset.cmd_ready", o_ready, 1'b1);
    check("reset.busy", o_busy, 1'b0);
    check("reset.tx_count", o_count, 3'd4);
    check("reset.rsp_code", o_code, 2'b00);
    check("reset.rsp_rdata", o_rdata, 16'h0000);
    check("reset.rsp_valid", o_rsp_valid, 1'b0);
    check("reset.tx_dv", o_tx_dv, 1'b0);
    check("reset.dropped", o_drop, 1'b0);

    // Directed write, read and bad opcode with a 20-cycle master.
    run_txn("wr", OP_WR, 8'h12, 16'hBEEF, T_MAIN);
    m_miso = '{8'h00, 8'h00, 8'hCA, 8'hFE};
    run_txn("rd", OP_RD, 8'h34, 16'h0000, T_MAIN);
    run_txn("badop", 8'h7F, 8'h56, 16'h1234, T_MAIN);

    // Frames arriving mid-transaction and in the rsp_valid cycle itself (2 + 4*(20+1)).
    inj_q.push_back(30);
    inj_q.push_back(2 + 4 * (20 + 1));
    run_txn("drop", OP_WR, 8'h55, 16'hA5C3, T_MAIN);

    // Timeout on the short-timeout instance: byte 1 answers only after 40 cycles.
    do_reset();
    sel    = 1'b1;
    m_dly  = '{5, 40, 5, 5};
    m_miso = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_txn("timeout", OP_RD, 8'h9A, 16'h0000, T_SHORT);
    do_reset();
    sel = 1'b0;

    // Reset asserted after the second byte.
    m_dly = '{20, 20, 20, 20};
    tx_q.delete();
    rsp_cnt = 0;
    q_valid = 1'b1; q_op = OP_WR; q_addr = 8'h77; q_wdata = 16'h0102;
    step();
    for (int i = 0; i < 200 && tx_q.size() < 2; i++) step();
    check("rst.bytes_before", tx_q.size(), 2);
    q_reset = 1'b1;
    step();
    check("rst.busy", o_busy, 1'b0);
    check("rst.cmd_ready", o_ready, 1'b1);
    check("rst.rsp_valid", o_rsp_valid, 1'b0);
    q_reset = 1'b0;
    for (int i = 0; i < 100 && (m_pending || i < 5); i++) step();
    check("rst.no_rsp", rsp_cnt, 0);
    check("rst.no_more_tx", tx_q.size(), 2);
    run_txn("after_rst", OP_WR, 8'h78, 16'h3456, T_MAIN);

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    r_op_sel = OP_WR;
        2, 3:    r_op_sel = OP_RD;
        default: r_op_sel = 8'(3 + $urandom_range(0, 250));
      endcase
      for (int k = 0; k < 4; k++) begin
        m_dly[k]  = $urandom_range(1, 25);
        m_miso[k] = 8'($urandom_range(0, 255));
      end
      run_txn($sformatf("rand%0d", n), r_op_sel, 8'($urandom_range(0, 255)),
              16'($urandom_range(0, 65535)), T_MAIN);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
